// File: rtl/ldpc_wb_host.sv
// rtl/ldpc_wb_host.sv - Wishbone classic burst master for the LDPC wbs port
module ldpc_wb_host #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_sel,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              wdata_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic              busy,
  output logic              wbs_cyc_o,
  output logic              wbs_stb_o,
  output logic              wbs_we_o,
  output logic [3:0]        wbs_sel_o,
  output logic [ADDR_W-1:0] wbs_adr_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  input  logic              wbs_ack_i,
  input  logic [DATA_W-1:0] wbs_dat_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam int TMO_W = 16;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        sel_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_q;
  logic [DATA_W-1:0] dat_q;
  logic [TMO_W-1:0]  tmo_q;

  logic cmd_hs;
  logic rsp_hs;
  logic more_beats;
  logic tmo_hit;

  assign cmd_hs     = (state_q == IDLE) && cmd_valid;
  assign rsp_hs     = (state_q == RESP) && rsp_ready;
  // An error beat always terminates the command, whatever the beat count
  assign more_beats = !rsp_err && (beat_q != len_q);
  // Last REQ cycle of the ack window; an ack in this same cycle still wins
  assign tmo_hit    = (tmo_q == TMO_LAST);

  assign wbs_we_o  = we_q;
  assign wbs_sel_o = sel_q;
  assign wbs_adr_o = addr_q;
  assign wbs_dat_o = dat_q;

  // State register; async reset drops cyc/stb immediately via the decode
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cmd_valid) state_d = REQ;
      REQ:   if (wbs_ack_i || tmo_hit) state_d = RESP;
      RESP:  if (rsp_ready) state_d = more_beats ? REQ : IDLE;
      ABORT: state_d = IDLE;
    endcase
  end

  // Output decode; the reserved encoding behaves as an inactive bus
  always_comb begin
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    wbs_cyc_o   = 1'b0;
    wbs_stb_o   = 1'b0;
    rsp_valid   = 1'b0;
    wdata_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready   = 1'b1;
        busy        = 1'b0;
        wdata_ready = cmd_valid && cmd_we;
      end
      REQ: begin
        wbs_cyc_o = 1'b1;
        wbs_stb_o = 1'b1;
      end
      RESP: begin
        rsp_valid   = 1'b1;
        wdata_ready = rsp_ready && more_beats && we_q;
      end
      ABORT: begin
        busy = 1'b1;
      end
    endcase
  end

  // Command latch, per-beat address/data advance and ack timeout counter
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      sel_q  <= '0;
      len_q  <= '0;
      beat_q <= '0;
      dat_q  <= '0;
      tmo_q  <= '0;
    end else begin
      if (cmd_hs) begin
        we_q   <= cmd_we;
        addr_q <= cmd_addr & ~ADDR_W'(3);
        sel_q  <= cmd_sel;
        len_q  <= cmd_len;
        beat_q <= '0;
        dat_q  <= cmd_we ? cmd_wdata : '0;
        tmo_q  <= '0;
      end
      if (state_q == REQ) begin
        if (wbs_ack_i || tmo_hit) tmo_q <= '0;
        else                      tmo_q <= tmo_q + 1'b1;
      end
      if (rsp_hs && more_beats) begin
        beat_q <= beat_q + 1'b1;
        addr_q <= addr_q + ADDR_W'(4);
        if (we_q) dat_q <= cmd_wdata;
      end
    end
  end

  // Response capture; held untouched for the whole RESP state
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_last  <= 1'b0;
    end else if (cmd_hs) begin
      rsp_err  <= 1'b0;
      rsp_last <= 1'b0;
    end else if (state_q == REQ) begin
      if (wbs_ack_i) begin
        rsp_rdata <= we_q ? '0 : wbs_dat_i;
        rsp_err   <= 1'b0;
        rsp_last  <= (beat_q == len_q);
      end else if (tmo_hit) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
        rsp_last  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_wb_host.sv
// tb/tb_ldpc_wb_host.sv - self-checking bench for ldpc_wb_host
module tb_ldpc_wb_host;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_sel;
  logic [3:0]  cmd_len;
  logic [31:0] cmd_wdata;
  logic        wdata_ready, rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_last, busy;
  logic        cyc, stb, bwe;
  logic [3:0]  bsel;
  logic [31:0] badr, bdo;
  logic        ack;
  logic [31:0] bdi;

  int total = 0;
  int bad   = 0;

  // Per-beat stimulus: slave wait states (>= TMO means never ack), response stall, data
  int          wait_a [16];
  int          stall_a[16];
  logic [31:0] wd_a   [16];
  logic [31:0] rd_a   [16];

  always #5 clk = ~clk;

  ldpc_wb_host #(.ADDR_W(32), .DATA_W(32), .LEN_W(4), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .cmd_wdata(cmd_wdata), .wdata_ready(wdata_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_last(rsp_last), .busy(busy),
    .wbs_cyc_o(cyc), .wbs_stb_o(stb), .wbs_we_o(bwe), .wbs_sel_o(bsel),
    .wbs_adr_o(badr), .wbs_dat_o(bdo), .wbs_ack_i(ack), .wbs_dat_i(bdi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < 16; k++) begin
      wait_a[k]  = 0;
      stall_a[k] = 0;
      wd_a[k]    = $urandom;
      rd_a[k]    = $urandom;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cyc"}, cyc, 0);
    chk({tag, "_stb"}, stb, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
  endtask

  // Issue one command and act as the slave; expectations come from the beat rules
  task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input int len);
    logic [31:0] ea;
    logic        err;
    logic        last;
    int          i;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_sel = sel;
    cmd_len = 4'(len); cmd_wdata = wd_a[0];
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("wdata_ready_first", wdata_ready, we);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wdata = $urandom;
    chk("busy_run", busy, 1);
    chk("cmd_ready_run", cmd_ready, 0);
    for (int b = 0; b <= len; b++) begin
      ea = (addr & 32'hFFFF_FFFC) + 32'(4 * b);
      i = 0;
      while (stb === 1'b1 && i < TMO + 4) begin
        if (i == 0) begin
          chk("bus_adr", badr, ea);
          chk("bus_we", bwe, we);
          chk("bus_sel", bsel, sel);
          chk("bus_cyc", cyc, 1);
          if (we) chk("bus_dat", bdo, wd_a[b]);
        end
        ack = (i == wait_a[b]);
        bdi = ack ? rd_a[b] : $urandom;
        @(negedge clk);
        i++;
      end
      ack = 1'b0;
      err  = (wait_a[b] >= TMO);
      last = err || (b == len);
      chk("stb_cycles", i, err ? TMO : wait_a[b] + 1);
      chk("cyc_low_resp", cyc, 0);
      for (int s = 0; s <= stall_a[b]; s++) begin
        // ack outside REQ must be ignored
        ack = (s < stall_a[b]) ? 1'($urandom_range(0, 1)) : 1'b0;
        bdi = $urandom;
        rsp_ready = (s == stall_a[b]);
        if (rsp_ready && !last) cmd_wdata = wd_a[b + 1];
        #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, err);
        chk("rsp_last", rsp_last, last);
        if (!err) chk("rsp_rdata", rsp_rdata, we ? 32'h0 : rd_a[b]);
        chk("stb_in_resp", stb, 0);
        chk("wdata_ready", wdata_ready, rsp_ready && we && !last);
        @(negedge clk);
      end
      rsp_ready = 1'b0;
      ack = 1'b0;
      if (err) break;
    end
    #1;
    check_idle_outputs("end");
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_sel = 0; cmd_len = 0; cmd_wdata = 0;
    rsp_ready = 0; ack = 0; bdi = 0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_we", bwe, 0);
    chk("reset_adr", badr, 0);
    chk("reset_dat", bdo, 0);
    chk("reset_sel", bsel, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_last", rsp_last, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_wdata_ready", wdata_ready, 0);
    rst_n = 1'b1;

    // Single write with two wait states
    clear_stim();
    wd_a[0] = 32'hDEAD_BEEF; wait_a[0] = 2;
    run_cmd(1'b1, 32'h3000_0004, 4'hF, 0);

    // Four-beat read burst, zero-wait slave
    clear_stim();
    rd_a[0] = 32'h11; rd_a[1] = 32'h22; rd_a[2] = 32'h33; rd_a[3] = 32'h44;
    run_cmd(1'b0, 32'h3000_0010, 4'hF, 3);

    // Timeout on the second beat ends the command
    clear_stim();
    wait_a[1] = 1000;
    run_cmd(1'b0, 32'h3000_0020, 4'h3, 3);

    // Response back-pressure in a write burst
    clear_stim();
    stall_a[0] = 5; stall_a[1] = 2;
    run_cmd(1'b1, 32'h3000_0100, 4'hC, 2);

    // Async reset while stb is high
    clear_stim();
    @(negedge clk);
    cmd_valid = 1; cmd_we = 0; cmd_addr = 32'h3000_0200; cmd_sel = 4'hF; cmd_len = 4'd2;
    @(negedge clk);
    cmd_valid = 0;
    chk("pre_reset_stb", stb, 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    chk("midreset_adr", badr, 0);
    chk("midreset_sel", bsel, 0);
    chk("midreset_we", bwe, 0);
    @(negedge clk);
    chk("held_reset_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    run_cmd(1'b0, 32'h3000_0300, 4'hF, 1);

    // Address wrap, and ack on exactly the last allowed cycle
    clear_stim();
    wait_a[0] = TMO - 1;
    run_cmd(1'b1, 32'hFFFF_FFFC, 4'hF, 1);

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      int r;
      clear_stim();
      for (int k = 0; k < 16; k++) begin
        r = $urandom_range(0, 19);
        if (r < 15)       wait_a[k] = $urandom_range(0, 3);
        else if (r == 15) wait_a[k] = TMO - 1;
        else if (r == 16) wait_a[k] = 1000;
        else              wait_a[k] = $urandom_range(0, TMO - 1);
        stall_a[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      end
      run_cmd(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 15));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
